acc_job_sequencer: RTL and testbench

Autonomous descriptor-driven launcher sitting directly upstream of the full-system wrapper: it drives that wrapper's CPU-side IOb port and the accelerator control inputs (start, input_addr, output_addr, N), and consumes its done. It fetches a list of job descriptors from memory, launches one int_sum job per descriptor, waits for completion and writes a status word back to the descriptor. Host software only supplies a descriptor base address and job count.

---
 rtl/acc_job_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_acc_job_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_job_sequencer.sv
// Descriptor-driven job launcher: fetches 4-word descriptors over IOb, launches one
// accelerator job per descriptor, waits for done and writes a status word back.
module acc_job_sequencer #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [ADDR_W-1:0]   desc_base,
    input  logic [15:0]         num_jobs,
    output logic                busy,
    output logic                list_done,
    output logic                err,
    output logic [15:0]         jobs_done,
    output logic                cpu_valid,
    output logic [ADDR_W-1:0]   cpu_addr,
    output logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W/8-1:0] cpu_wstrb,
    input  logic [DATA_W-1:0]   cpu_rdata,
    input  logic                cpu_rvalid,
    input  logic                cpu_ready,
    output logic                start,
    output logic [ADDR_W-1:0]   input_addr,
    output logic [ADDR_W-1:0]   output_addr,
    output logic [31:0]         N,
    input  logic                done
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, START, RUN, WB, NEXT, FIN} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   base, base_next;
    logic [15:0]         total, total_next;
    logic [15:0]         job_idx, job_idx_next;
    logic [1:0]          word, word_next;
    logic [DATA_W-1:0]   w0, w0_next, w1, w1_next;
    logic [31:0]         tmo, tmo_next;
    logic                seen_low, seen_low_next;

    logic                busy_next, list_done_next, err_next, start_next, cpu_valid_next;
    logic [15:0]         jobs_done_next;
    logic [ADDR_W-1:0]   cpu_addr_next, input_addr_next, output_addr_next;
    logic [DATA_W-1:0]   cpu_wdata_next;
    logic [STRB_W-1:0]   cpu_wstrb_next;
    logic [31:0]         n_next;
    logic [31:0]         status;

    function automatic logic [ADDR_W-1:0] desc_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [15:0] idx,
                                                    input logic [3:0] off);
        return b + ADDR_W'({idx, 4'b0000}) + ADDR_W'(off);
    endfunction

    always_comb begin
        state_next       = state;
        base_next        = base;
        total_next       = total;
        job_idx_next     = job_idx;
        word_next        = word;
        w0_next          = w0;
        w1_next          = w1;
        tmo_next         = tmo;
        seen_low_next    = seen_low;
        err_next         = err;
        jobs_done_next   = jobs_done;
        input_addr_next  = input_addr;
        output_addr_next = output_addr;
        n_next           = N;

        case (state)
            IDLE: begin
                if (go) begin
                    base_next      = {desc_base[ADDR_W-1:2], 2'b00};
                    total_next     = num_jobs;
                    job_idx_next   = 16'd0;
                    word_next      = 2'd0;
                    jobs_done_next = 16'd0;
                    err_next       = 1'b0;
                    state_next     = (num_jobs == 16'd0) ? FIN : RD_REQ;
                end
            end
            RD_REQ: begin
                if (cpu_valid && cpu_ready) state_next = RD_WAIT;
            end
            RD_WAIT: begin
                // Job parameters move to the outputs only as word2 lands, so they
                // stay stable for the whole previous job.
                if (cpu_rvalid) begin
                    case (word)
                        2'd0:    w0_next = cpu_rdata;
                        2'd1:    w1_next = cpu_rdata;
                        default: begin
                            input_addr_next  = w0[ADDR_W-1:0];
                            output_addr_next = w1[ADDR_W-1:0];
                            n_next           = cpu_rdata[31:0];
                        end
                    endcase
                    if (word == 2'd2) begin
                        state_next = START;
                    end else begin
                        word_next  = word + 2'd1;
                        state_next = RD_REQ;
                    end
                end
            end
            START: begin
                tmo_next      = 32'd0;
                seen_low_next = 1'b0;
                state_next    = (N == 32'd0) ? WB : RUN;
            end
            RUN: begin
                // A done that never dropped since launch belongs to the previous job.
                if (seen_low && done) begin
                    state_next = WB;
                end else if (tmo == 32'(TIMEOUT_CYC - 1)) begin
                    err_next   = 1'b1;
                    state_next = FIN;
                end else begin
                    tmo_next = tmo + 32'd1;
                    if (!done) seen_low_next = 1'b1;
                end
            end
            WB: begin
                if (cpu_valid && cpu_ready) begin
                    jobs_done_next = (jobs_done == 16'hFFFF) ? jobs_done : jobs_done + 16'd1;
                    state_next     = NEXT;
                end
            end
            NEXT: begin
                job_idx_next = job_idx + 16'd1;
                word_next    = 2'd0;
                state_next   = (job_idx + 16'd1 == total) ? FIN : RD_REQ;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Outputs are derived from the upcoming state so they can be registered.
        status         = {1'b1, (n_next == 32'd0), 14'd0, job_idx_next};
        cpu_valid_next = (state_next == RD_REQ) || (state_next == WB);
        cpu_wstrb_next = (state_next == WB) ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
        cpu_addr_next  = cpu_addr;
        cpu_wdata_next = cpu_wdata;
        if (state_next == RD_REQ) begin
            cpu_addr_next = desc_addr(base_next, job_idx_next, {word_next, 2'b00});
        end else if (state_next == WB) begin
            cpu_addr_next  = desc_addr(base_next, job_idx_next, 4'd12);
            cpu_wdata_next = DATA_W'(status);
        end
        start_next     = (state_next == START) && (n_next != 32'd0);
        list_done_next = (state_next == FIN);
        busy_next      = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            base        <= '0;
            total       <= '0;
            job_idx     <= '0;
            word        <= '0;
            w0          <= '0;
            w1          <= '0;
            tmo         <= '0;
            seen_low    <= 1'b0;
            busy        <= 1'b0;
            list_done   <= 1'b0;
            err         <= 1'b0;
            jobs_done   <= '0;
            cpu_valid   <= 1'b0;
            cpu_addr    <= '0;
            cpu_wdata   <= '0;
            cpu_wstrb   <= '0;
            start       <= 1'b0;
            input_addr  <= '0;
            output_addr <= '0;
            N           <= '0;
        end else begin
            state       <= state_next;
            base        <= base_next;
            total       <= total_next;
            job_idx     <= job_idx_next;
            word        <= word_next;
            w0          <= w0_next;
            w1          <= w1_next;
            tmo         <= tmo_next;
            seen_low    <= seen_low_next;
            busy        <= busy_next;
            list_done   <= list_done_next;
            err         <= err_next;
            jobs_done   <= jobs_done_next;
            cpu_valid   <= cpu_valid_next;
            cpu_addr    <= cpu_addr_next;
            cpu_wdata   <= cpu_wdata_next;
            cpu_wstrb   <= cpu_wstrb_next;
            start       <= start_next;
            input_addr  <= input_addr_next;
            output_addr <= output_addr_next;
            N           <= n_next;
        end
    end

endmodule

// File: tb/tb_acc_job_sequencer.sv
// Bench for acc_job_sequencer: memory and accelerator models plus a transaction-level
// model of the expected IOb traffic, launches and list results.
module tb_acc_job_sequencer;

    localparam int TMO = 16;
    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [31:0] desc_base = '0;
    logic [15:0] num_jobs = '0;
    logic        busy, list_done, err, cpu_valid, start;
    logic [15:0] jobs_done;
    logic [31:0] cpu_addr, cpu_wdata, input_addr, output_addr, N;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata = '0;
    logic        cpu_rvalid = 1'b0;
    logic        cpu_ready = 1'b0;
    logic        done = 1'b0;

    acc_job_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .go(go), .desc_base(desc_base), .num_jobs(num_jobs),
        .busy(busy), .list_done(list_done), .err(err), .jobs_done(jobs_done),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .cpu_ready(cpu_ready), .start(start), .input_addr(input_addr),
        .output_addr(output_addr), .N(N), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { bit [31:0] addr; bit wr; bit [31:0] data; } txn_t;
    typedef struct { bit [31:0] ia; bit [31:0] oa; bit [31:0] n; } job_t;

    int n_checks = 0;
    int n_fail = 0;
    bit [31:0] mem [bit [31:0]];
    txn_t exp_txn[$];
    job_t exp_start[$];
    int exp_jobs = 0;
    bit exp_err = 0;
    int ld_seen = 0;
    int ld_target = 0;
    int cyc = 0;
    int start_cyc = 0;

    bit stall_en = 0;
    int rd_lat = 1;
    int rd_cnt = 0;
    bit rd_pend = 0;
    bit [31:0] rd_addr = 0;
    bit prev_valid = 0, prev_ready = 0;
    bit [31:0] prev_addr = 0, prev_wdata = 0;
    bit [3:0] prev_wstrb = 0;

    int acc_mode = 0;
    bit acc_busy = 0;
    int acc_cnt = 0;
    bit [31:0] acc_out = 0, acc_sum = 0;
    txn_t t;
    job_t jb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        bit [31:0] k = a & ~32'h3;
        if (mem.exists(k)) return mem[k];
        return 32'h0;
    endfunction

    task automatic set_desc(input bit [31:0] a, input bit [31:0] ia, input bit [31:0] oa, input bit [31:0] n);
        mem[a] = ia; mem[a + 4] = oa; mem[a + 8] = n; mem[a + 12] = 32'h0;
    endtask

    // Expected traffic for a list: 3 reads per descriptor, a launch unless N==0,
    // then a status write; the list stops without writeback at the timed-out job.
    task automatic plan(input bit [31:0] b_in, input int n, input int tmo_job);
        bit [31:0] b, a, nj;
        b = b_in & ~32'h3;
        exp_jobs = n;
        exp_err = 0;
        for (int j = 0; j < n; j++) begin
            a = b + 32'(j) * 16;
            for (int w = 0; w < 3; w++) exp_txn.push_back('{addr: a + 32'(w) * 4, wr: 1'b0, data: 32'h0});
            nj = mem_rd(a + 8);
            if (nj != 0) exp_start.push_back('{ia: mem_rd(a), oa: mem_rd(a + 4), n: nj});
            if (j == tmo_job) begin
                exp_err = 1;
                exp_jobs = j;
                break;
            end
            exp_txn.push_back('{addr: a + 12, wr: 1'b1, data: {1'b1, nj == 0, 14'b0, 16'(j)}});
        end
    endtask

    // Memory, accelerator and per-cycle comparison all live in one negedge process.
    always @(negedge clk) begin
        cyc++;
        cpu_rvalid = 1'b0;
        if (rd_pend) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                cpu_rvalid = 1'b1;
                cpu_rdata = mem_rd(rd_addr);
                rd_pend = 0;
            end
        end
        if (reset) begin
            prev_valid = 0;
            acc_busy = 0;
            done = 1'b0;
            cpu_ready = 1'b0;
        end else begin
            if (acc_busy) begin
                acc_cnt++;
                if (acc_mode == 1 && acc_cnt == 2) done = 1'b0;
                if (acc_mode != 2 && acc_cnt == LAT) begin
                    done = 1'b1;
                    mem[acc_out & ~32'h3] = acc_sum;
                    acc_busy = 0;
                end
            end
            if (prev_valid && !prev_ready)
                check("req_hold", {28'h0, cpu_valid, cpu_addr == prev_addr, cpu_wdata == prev_wdata, cpu_wstrb == prev_wstrb}, 32'hF);
            if (cpu_valid || start) check("busy_active", busy, 1);
            if (start) begin
                start_cyc = cyc;
                check("start_expected", exp_start.size() != 0, 1);
                if (exp_start.size() != 0) begin
                    jb = exp_start.pop_front();
                    check("start_input_addr", input_addr, jb.ia);
                    check("start_output_addr", output_addr, jb.oa);
                    check("start_N", N, jb.n);
                end
                acc_busy = 1;
                acc_cnt = 0;
                acc_out = output_addr;
                acc_sum = 0;
                for (int i = 0; i < int'(N) && i < 64; i++) acc_sum += mem_rd(input_addr + 32'(i) * 4);
                if (acc_mode != 1) done = 1'b0;
            end
            if (list_done) begin
                ld_seen++;
                check("list_jobs_done", jobs_done, exp_jobs);
                check("list_err", err, exp_err);
                if (exp_err) check("timeout_window", (cyc - start_cyc) >= TMO && (cyc - start_cyc) <= TMO + 2, 1);
            end
            cpu_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (cpu_valid && cpu_ready) begin
                check("txn_expected", exp_txn.size() != 0, 1);
                if (exp_txn.size() != 0) begin
                    t = exp_txn.pop_front();
                    check("txn_addr", cpu_addr, t.addr);
                    check("txn_wstrb", cpu_wstrb, t.wr ? 32'hF : 32'h0);
                    if (t.wr) begin
                        check("txn_wdata", cpu_wdata, t.data);
                        check("wb_after_done", acc_busy, 0);
                    end
                end
                if (cpu_wstrb != 0) begin
                    mem[cpu_addr & ~32'h3] = cpu_wdata;
                end else begin
                    rd_pend = 1;
                    rd_cnt = rd_lat;
                    rd_addr = cpu_addr;
                end
            end
            prev_valid = cpu_valid;
            prev_ready = cpu_ready;
            prev_addr = cpu_addr;
            prev_wdata = cpu_wdata;
            prev_wstrb = cpu_wstrb;
        end
    end

    task automatic apply_stimulus(input bit [31:0] b, input bit [15:0] n);
        ld_target = ld_seen + 1;
        @(posedge clk); #2;
        desc_base = b; num_jobs = n; go = 1'b1;
        @(posedge clk); #1;
        check("go_busy", busy, 1);
        check("go_first_valid", cpu_valid, n != 0);
        if (n == 0) check("go_empty_list_done", list_done, 1);
        #1 go = 1'b0;
    endtask

    task automatic wait_list_done();
        for (int i = 0; i < 4000 && ld_seen < ld_target; i++) @(posedge clk);
        #1;
        check("list_done_seen", ld_seen >= ld_target, 1);
        check("busy_after_fin", busy, 0);
        check("txn_left", exp_txn.size(), 0);
        check("start_left", exp_start.size(), 0);
        #1;
    endtask

    task automatic check_output_reset();
        check("rst_cpu_valid", cpu_valid, 0);
        check("rst_cpu_addr", cpu_addr, 0);
        check("rst_cpu_wdata", cpu_wdata, 0);
        check("rst_cpu_wstrb", cpu_wstrb, 0);
        check("rst_start", start, 0);
        check("rst_input_addr", input_addr, 0);
        check("rst_output_addr", output_addr, 0);
        check("rst_N", N, 0);
        check("rst_busy", busy, 0);
        check("rst_list_done", list_done, 0);
        check("rst_err", err, 0);
        check("rst_jobs_done", jobs_done, 0);
    endtask

    task automatic reset_now();
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check_output_reset();
        #1 reset = 1'b0;
        exp_txn.delete();
        exp_start.delete();
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit flag;
        for (int i = 0; i < 16; i++) mem[32'h1000 + 32'(i) * 4] = 32'(i + 1);
        repeat (3) @(posedge clk);
        #1 check_output_reset();
        #1 reset = 1'b0;

        $display("[TB] single descriptor");
        set_desc(32'h100, 32'h1000, 32'h2000, 8);
        plan(32'h100, 1, -1);
        apply_stimulus(32'h100, 1);
        wait_list_done();
        check("t1_sum", mem_rd(32'h2000), 36);
        check("t1_status", mem_rd(32'h10C), 32'h80000000);
        check("t1_jobs_done", jobs_done, 1);

        $display("[TB] three descriptors with ready stalls, go while busy");
        set_desc(32'h100, 32'h1000, 32'h2000, 8);
        set_desc(32'h110, 32'h1000, 32'h2100, 4);
        set_desc(32'h120, 32'h1010, 32'h2200, 3);
        stall_en = 1;
        plan(32'h100, 3, -1);
        apply_stimulus(32'h100, 3);
        repeat (4) @(posedge clk);
        #2 desc_base = 32'h500; num_jobs = 16'd7; go = 1'b1;
        @(posedge clk); #2 go = 1'b0;
        wait_list_done();
        check("t2_status0", mem_rd(32'h10C), 32'h80000000);
        check("t2_status1", mem_rd(32'h11C), 32'h80000001);
        check("t2_status2", mem_rd(32'h12C), 32'h80000002);
        check("t2_sum1", mem_rd(32'h2100), 10);
        check("t2_sum2", mem_rd(32'h2200), 18);

        $display("[TB] skipped N=0 descriptor, unaligned base");
        stall_en = 0;
        set_desc(32'h300, 32'h1000, 32'h2300, 2);
        set_desc(32'h310, 32'h1000, 32'h2400, 0);
        set_desc(32'h320, 32'h1004, 32'h2500, 2);
        mem[32'h2400] = 32'hDEAD;
        plan(32'h300, 3, -1);
        apply_stimulus(32'h302, 3);
        wait_list_done();
        check("t3_status0", mem_rd(32'h30C), 32'h80000000);
        check("t3_status1", mem_rd(32'h31C), 32'hC0000001);
        check("t3_status2", mem_rd(32'h32C), 32'h80000002);
        check("t3_sum0", mem_rd(32'h2300), 3);
        check("t3_skip_untouched", mem_rd(32'h2400), 32'hDEAD);
        check("t3_sum2", mem_rd(32'h2500), 5);

        $display("[TB] empty list");
        plan(32'h100, 0, -1);
        apply_stimulus(32'h100, 0);
        wait_list_done();
        check("t4_jobs_done", jobs_done, 0);

        $display("[TB] stale done from previous job");
        acc_mode = 1;
        set_desc(32'h100, 32'h1000, 32'h2000, 8);
        set_desc(32'h110, 32'h1000, 32'h2100, 4);
        plan(32'h100, 2, -1);
        apply_stimulus(32'h100, 2);
        wait_list_done();
        check("t5_status1", mem_rd(32'h11C), 32'h80000001);

        $display("[TB] timeout with done stuck low");
        acc_mode = 2;
        set_desc(32'h100, 32'h1000, 32'h2000, 8);
        plan(32'h100, 2, 0);
        apply_stimulus(32'h100, 2);
        wait_list_done();
        check("t6_no_status", mem_rd(32'h10C), 0);
        check("t6_err", err, 1);
        check("t6_jobs_done", jobs_done, 0);

        $display("[TB] err cleared by next go");
        acc_mode = 0;
        plan(32'h110, 1, -1);
        apply_stimulus(32'h110, 1);
        wait_list_done();
        check("t7_err_clear", err, 0);

        $display("[TB] reset during descriptor read");
        rd_lat = 3;
        plan(32'h100, 1, -1);
        apply_stimulus(32'h100, 1);
        for (int i = 0; i < 50 && !rd_pend; i++) @(posedge clk);
        check("t8_read_pending", rd_pend, 1);
        reset_now();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("t8_idle_busy", busy, 0);
            check("t8_idle_valid", cpu_valid, 0);
        end
        rd_lat = 1;

        $display("[TB] reset during run");
        plan(32'h100, 1, -1);
        apply_stimulus(32'h100, 1);
        for (int i = 0; i < 100 && !acc_busy; i++) @(posedge clk);
        flag = acc_busy;
        check("t9_reached_run", flag, 1);
        repeat (2) @(posedge clk);
        reset_now();
        repeat (3) @(posedge clk);

        $display("[TB] clean list after resets");
        stall_en = 1;
        set_desc(32'h100, 32'h1000, 32'h2000, 8);
        set_desc(32'h110, 32'h1000, 32'h2100, 4);
        set_desc(32'h120, 32'h1010, 32'h2200, 3);
        plan(32'h100, 3, -1);
        apply_stimulus(32'h100, 3);
        wait_list_done();
        check("t10_status0", mem_rd(32'h10C), 32'h80000000);
        check("t10_status1", mem_rd(32'h11C), 32'h80000001);
        check("t10_status2", mem_rd(32'h12C), 32'h80000002);
        check("t10_jobs_done", jobs_done, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
